// File: rtl/ram_controller_if.sv
// Request/response channel between the datapath MAR/MDR transfer logic and ram_controller.
interface ram_controller_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_write;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    // Requester side: issues requests, consumes responses.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_err
    );

    // Controller side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_err
    );
endinterface

// File: rtl/ram_controller.sv
// CPU-side initiator for the single-port synchronous RAM: one request at a time,
// absorbs the RAM's registered-read latency, returns results on a held response.
// Optional write-verify readback enabled by defining RAM_CTRL_WRITE_VERIFY_EN.
module ram_controller #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clear,
    ram_controller_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        RADDR = 3'd2,
        RDATA = 3'd3,
        RESP  = 3'd4
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        ,
        VADDR = 3'd5,
        VDATA = 3'd6
`endif
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] mar;
    logic [ADDR_WIDTH-1:0] mar_d;
    logic [DATA_WIDTH-1:0] mdr;
    logic [DATA_WIDTH-1:0] mdr_d;
    logic                  is_write;
    logic                  is_write_d;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic                  err;
    logic                  err_d;
`endif

    // State register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // MAR/MDR/type (and verify error) registers.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            mar      <= '0;
            mdr      <= '0;
            is_write <= 1'b0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            err      <= 1'b0;
`endif
        end else begin
            mar      <= mar_d;
            mdr      <= mdr_d;
            is_write <= is_write_d;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            err      <= err_d;
`endif
        end
    end

    // Next-state, register updates and state-decoded strobes.
    always_comb begin
        state_d       = state;
        mar_d         = mar;
        mdr_d         = mdr;
        is_write_d    = is_write;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        err_d         = err;
`endif
        ram_we        = 1'b0;
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    mar_d      = bus.req_addr;
                    mdr_d      = bus.req_wdata;
                    is_write_d = bus.req_write;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                    err_d      = 1'b0;
`endif
                    state_d    = bus.req_write ? WRITE : RADDR;
                end
            end
            WRITE: begin
                // RAM commits MDR at MAR on the edge closing this cycle.
                ram_we = 1'b1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                state_d = VADDR;
`else
                state_d = RESP;
`endif
            end
            RADDR: begin
                // RAM registers MAR as its read address on the closing edge.
                state_d = RDATA;
            end
            RDATA: begin
                mdr_d   = ram_rdata;
                state_d = RESP;
            end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            VADDR: begin
                state_d = VDATA;
            end
            VDATA: begin
                // MDR still holds the written word here, compare before replacing it.
                err_d   = (ram_rdata != mdr);
                mdr_d   = ram_rdata;
                state_d = RESP;
            end
`endif
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM pins mirror MAR/MDR directly so the bus holds still in IDLE.
    assign ram_addr       = mar;
    assign ram_wdata      = mdr;

    // Response payload comes straight from the registers and is stable while held.
    assign bus.resp_rdata = mdr;
    assign bus.resp_write = is_write;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    assign bus.resp_err   = err;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_controller.sv
// Randomised scoreboard bench for ram_controller with a behavioural RAM model.
// Define RAM_CTRL_WRITE_VERIFY_EN to exercise the write-verify build.
module tb_ram_controller;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    localparam int WR_LAT = 4;
`else
    localparam int WR_LAT = 2;
`endif
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic          write;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk;
    logic          clear;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] ram_q;
    logic          ram_we;

    ram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .clear     (clear),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // Power-up contents of the RAM: a recognisable per-address pattern.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    // Behavioural single-port RAM: write on edge, registered read address.
    bit [DW-1:0] mem [DEPTH];
    bit          written [DEPTH];
    bit [AW-1:0] ram_areg;
    bit          zero_rd;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_areg <= ram_addr;
    end

    assign ram_q     = written[ram_areg] ? mem[ram_areg] : init_val(ram_areg);
    assign ram_rdata = zero_rd ? '0 : ram_q;

    // Reference memory: only addresses that have been written are stored.
    logic [DW-1:0] ref_mem [int];
    exp_t          exp_q [$];
    int            tests;
    int            fails;
    bit            rr_random;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; optionally randomise resp_ready.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rr_random) bus.resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present a request until accepted; queue its expected response.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit expect_resp, input bit bad_verify, output int waited);
        exp_t e;
        bit   ok;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        waited = 0;
        ok     = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        if (!ok) begin
            check("accept_timeout", 64'(bus.req_ready), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (expect_resp) begin
            e.write = w;
            e.err   = 1'b0;
            if (w) begin
                e.rdata = bad_verify ? '0 : d;
                e.err   = bad_verify;
                ref_mem[int'(a)] = d;
            end else begin
                e.rdata = ref_read(a);
            end
            exp_q.push_back(e);
        end
        #1;
        bus.req_valid = 1'b0;
        if (rr_random) bus.resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Measure accept-to-response latency and the write strobe seen on the RAM pins.
    task automatic wait_resp(input string tag, input int exp_lat, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        int            lat;
        int            we_cnt;
        logic [AW-1:0] we_a;
        logic [DW-1:0] we_d;
        lat    = 0;
        we_cnt = 0;
        we_a   = '0;
        we_d   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                we_a = ram_addr;
                we_d = ram_wdata;
            end
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
            tick();
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_we_cycles"}, 64'(we_cnt), 64'(w));
        if (w) begin
            check({tag, "_we_addr"}, 64'(we_a), 64'(a));
            check({tag, "_we_data"}, 64'(we_d), 64'(d));
        end
    endtask

    // Scoreboard monitor: compare each accepted response with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (clear && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'(bus.resp_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("resp_write", 64'(bus.resp_write), 64'(e.write));
                check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
                check("resp_err",   64'(bus.resp_err),   64'(e.err));
            end
        end
    end

    // Directed sequence followed by randomised traffic.
    initial begin
        int            waited;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        clear          = 1'b0;
        rr_random      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_addr   = AW'($urandom);
            bus.req_wdata  = $urandom;
            bus.resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_req_ready",  64'(bus.req_ready),  64'(1));
            check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
            check("rst_ram_we",     64'(ram_we),         64'(0));
            check("rst_ram_addr",   64'(ram_addr),       64'(0));
            check("rst_ram_wdata",  64'(ram_wdata),      64'(0));
            check("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
            check("rst_resp_write", 64'(bus.resp_write), 64'(0));
            check("rst_resp_err",   64'(bus.resp_err),   64'(0));
        end
        @(posedge clk);
        #1;
        clear          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;

        // First write right after release, then read it back.
        issue(1'b1, 9'h005, 32'hDEAD_BEEF, 1'b1, 1'b0, waited);
        check("first_accept_wait", 64'(waited), 64'(0));
        wait_resp("wr005", WR_LAT, 1'b1, 9'h005, 32'hDEAD_BEEF);
        tick();
        issue(1'b0, 9'h005, 32'h0, 1'b1, 1'b0, waited);
        check("rd005_wait", 64'(waited), 64'(0));
        wait_resp("rd005", RD_LAT, 1'b0, 9'h005, 32'h0);

        // Hold the response while a new request waits at the input.
        tick();
        bus.resp_ready = 1'b0;
        issue(1'b0, 9'h005, 32'h0, 1'b1, 1'b0, waited);
        wait_resp("hold_rd", RD_LAT, 1'b0, 9'h005, 32'h0);
        tick();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 9'h0AA;
        bus.req_wdata = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("hold_resp_rdata", 64'(bus.resp_rdata), 64'(32'hDEAD_BEEF));
            check("hold_resp_write", 64'(bus.resp_write), 64'(0));
            check("hold_resp_err",   64'(bus.resp_err),   64'(0));
            check("hold_req_ready",  64'(bus.req_ready),  64'(0));
            check("hold_ram_addr",   64'(ram_addr),       64'(9'h005));
            tick();
        end
        bus.resp_ready = 1'b1;
        issue(1'b0, 9'h0AA, 32'h0, 1'b1, 1'b0, waited);
        check("hold_release_wait", 64'(waited), 64'(1));
        wait_resp("rd0aa", RD_LAT, 1'b0, 9'h0AA, 32'h0);

        // Top-of-range address and untouched address 0.
        tick();
        issue(1'b1, 9'h1FF, 32'h1234_5678, 1'b1, 1'b0, waited);
        wait_resp("wr1ff", WR_LAT, 1'b1, 9'h1FF, 32'h1234_5678);
        tick();
        issue(1'b0, 9'h1FF, 32'h0, 1'b1, 1'b0, waited);
        wait_resp("rd1ff", RD_LAT, 1'b0, 9'h1FF, 32'h0);
        tick();
        issue(1'b0, 9'h000, 32'h0, 1'b1, 1'b0, waited);
        check("rd000_wait", 64'(waited), 64'(0));
        wait_resp("rd000", RD_LAT, 1'b0, 9'h000, 32'h0);

        // Abort a write mid-cycle: strobe drops at once, memory keeps its old word.
        tick();
        issue(1'b1, 9'h010, 32'hBAD0_BAD0, 1'b0, 1'b0, waited);
        check("abort_we_before", 64'(ram_we), 64'(1));
        #2;
        clear = 1'b0;
        #1;
        check("abort_we_async",   64'(ram_we),         64'(0));
        check("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("abort_req_ready",  64'(bus.req_ready),  64'(1));
        check("abort_ram_addr",   64'(ram_addr),       64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b1;
        issue(1'b0, 9'h010, 32'h0, 1'b1, 1'b0, waited);
        wait_resp("rd010", RD_LAT, 1'b0, 9'h010, 32'h0);

`ifdef RAM_CTRL_WRITE_VERIFY_EN
        // Corrupt the readback to provoke a verify error, then confirm it clears.
        tick();
        issue(1'b1, 9'h020, 32'hCAFE_F00D, 1'b1, 1'b1, waited);
        zero_rd = 1'b1;
        wait_resp("vfy_bad", WR_LAT, 1'b1, 9'h020, 32'hCAFE_F00D);
        zero_rd = 1'b0;
        tick();
        issue(1'b0, 9'h020, 32'h0, 1'b1, 1'b0, waited);
        wait_resp("vfy_rd", RD_LAT, 1'b0, 9'h020, 32'h0);
        tick();
        issue(1'b1, 9'h020, 32'h1111_2222, 1'b1, 1'b0, waited);
        wait_resp("vfy_ok", WR_LAT, 1'b1, 9'h020, 32'h1111_2222);
`endif

        // Randomised traffic with random response back-pressure.
        rr_random = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) tick();
            tick();
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 9'h1FF;
                1:       a = 9'h000;
                default: a = AW'($urandom_range(0, 15));
            endcase
            d = $urandom;
            issue(w, a, d, 1'b1, 1'b0, waited);
            wait_resp("rnd", w ? WR_LAT : RD_LAT, w, a, d);
        end

        // Drain outstanding responses.
        rr_random = 1'b0;
        tick();
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain_queue", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
